// File: rtl/step_debounce_pkg.sv
// Shared definitions for the step-button debouncer: FSM encoding and sample counter width.
package step_debounce_pkg;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam int SAMPLE_CNT_W = 8;

    function automatic logic is_qualifying(input logic [1:0] st);
        return (st == PRESS_WAIT) || (st == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; clears to 0 on reset.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_debounce.sv
// Push-button debouncer producing one step pulse per clean press, sampled on the slow tick.
// Optional auto-repeat while held is built when STEP_DEBOUNCE_REPEAT_EN is defined.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | high samples being qualified
// HELD         | press accepted, button stable high
// RELEASE_WAIT | low samples being qualified
module step_debounce
    import step_debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int CNT_W          = 8,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_raw,
    output logic             step_pulse,
    output logic             btn_level,
    output logic [CNT_W-1:0] press_count,
    output logic             busy
);

    localparam logic [SAMPLE_CNT_W-1:0] STABLE_LIM = SAMPLE_CNT_W'(STABLE_SAMPLES);
    localparam logic [SAMPLE_CNT_W-1:0] CNT_ONE    = SAMPLE_CNT_W'(1);

    logic                    btn_s;
    logic [1:0]              state, state_nxt;
    logic [SAMPLE_CNT_W-1:0] sample_cnt, cnt_nxt, cnt_inc;
    logic                    accept;
    logic                    release_done;
    logic                    repeat_fire;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    assign cnt_inc = (sample_cnt == '1) ? sample_cnt : sample_cnt + CNT_ONE;
    assign busy    = is_qualifying(state);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = sample_cnt;
        accept       = 1'b0;
        release_done = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        if (STABLE_LIM <= CNT_ONE) begin
                            state_nxt = HELD;
                            cnt_nxt   = '0;
                            accept    = 1'b1;
                        end else begin
                            state_nxt = PRESS_WAIT;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_inc >= STABLE_LIM) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        accept    = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        if (STABLE_LIM <= CNT_ONE) begin
                            state_nxt    = IDLE;
                            cnt_nxt      = '0;
                            release_done = 1'b1;
                        end else begin
                            state_nxt = RELEASE_WAIT;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt_inc >= STABLE_LIM) begin
                        state_nxt    = IDLE;
                        cnt_nxt      = '0;
                        release_done = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef STEP_DEBOUNCE_REPEAT_EN
    localparam int RPT_W = 16;

    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt, rpt_inc, rpt_target;
    logic             rpt_periodic, rpt_periodic_nxt;

    // First repeat waits REPEAT_DELAY held ticks, later ones REPEAT_PERIOD.
    assign rpt_inc    = rpt_cnt + RPT_W'(1);
    assign rpt_target = rpt_periodic ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);

    always_comb begin
        rpt_cnt_nxt      = rpt_cnt;
        rpt_periodic_nxt = rpt_periodic;
        repeat_fire      = 1'b0;
        if ((state != HELD) || (state_nxt != HELD)) begin
            rpt_cnt_nxt      = '0;
            rpt_periodic_nxt = 1'b0;
        end else if (tick && btn_s) begin
            if (rpt_inc == rpt_target) begin
                repeat_fire      = 1'b1;
                rpt_cnt_nxt      = '0;
                rpt_periodic_nxt = 1'b1;
            end else begin
                rpt_cnt_nxt = rpt_inc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
        end else begin
            rpt_cnt      <= rpt_cnt_nxt;
            rpt_periodic <= rpt_periodic_nxt;
        end
    end
`else
    logic unused_rpt_cfg;

    assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign repeat_fire    = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            step_pulse  <= 1'b0;
            btn_level   <= 1'b0;
            press_count <= '0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= cnt_nxt;
            step_pulse <= accept | repeat_fire;
            if (accept || repeat_fire) begin
                press_count <= press_count + CNT_W'(1);
            end
            if (accept) begin
                btn_level <= 1'b1;
            end else if (release_done) begin
                btn_level <= 1'b0;
            end
        end
    end

endmodule
